// File: rtl/tc3_pkg.sv
// Shared types and derived sizes for the Toom-Cook-3 interpolation/recomposition stage.
package tc3_pkg;

  // Signed width of pointwise products and interpolation intermediates.
  function automatic int pw_of(input int limb_w);
    return 2 * limb_w + 8;
  endfunction

  // Rising edges from the accept edge to out_valid.
  function automatic int lat_of(input int limb_w);
    return pw_of(limb_w) + 4;
  endfunction

  typedef enum logic [2:0] {
    IDLE, E1, E2, E3, DIV, R1, RC, OUT
  } state_t;

  typedef logic [1:0] rem_t;

endpackage

// File: rtl/tc3_interp_recomp_if.sv
// Product-set input handshake and result output handshake of the interpolation stage.
interface tc3_interp_recomp_if import tc3_pkg::*; #(parameter int LIMB_W = 64);

  localparam int PW = pw_of(LIMB_W);
  localparam int RW = 6 * LIMB_W;

  logic                 in_valid;
  logic                 in_ready;
  logic signed [PW-1:0] v0;
  logic signed [PW-1:0] v1;
  logic signed [PW-1:0] vm1;
  logic signed [PW-1:0] v2;
  logic signed [PW-1:0] vinf;
  logic [RW-1:0]        addend;
  logic                 out_valid;
  logic                 out_ready;
  logic [RW-1:0]        result;
  logic                 out_carry;
  logic                 out_err;

  modport master (
    output in_valid, v0, v1, vm1, v2, vinf, addend, out_ready,
    input  in_ready, out_valid, result, out_carry, out_err
  );

  modport slave (
    input  in_valid, v0, v1, vm1, v2, vinf, addend, out_ready,
    output in_ready, out_valid, result, out_carry, out_err
  );

endinterface

// File: rtl/tc3_div3_serial.sv
// Bit-serial exact divide-by-3 on |dividend|, quotient MSB-first one bit per cycle.
// The start edge consumes the top two magnitude bits; done pulses when the quotient is final.
module tc3_div3_serial import tc3_pkg::*; #(
  parameter int PW = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic signed [PW-1:0] dividend,
  output logic                 busy,
  output logic                 done,
  output logic signed [PW-1:0] quotient,
  output rem_t                 remainder
);

  localparam int CW = $clog2(PW);

  logic [PW-1:0] mag;
  logic [PW-1:0] sh;
  logic [CW-1:0] cnt;
  logic [2:0]    trial;
  rem_t          rem_q;
  logic          neg;

  // |dividend| <= 2^(PW-1), so its top two bits are at most 2'b10 and need no subtract.
  assign mag   = dividend[PW-1] ? $unsigned(-dividend) : $unsigned(dividend);
  assign trial = {rem_q, sh[PW-1]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: every register here, datapath included, is reset so outputs are defined after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      neg   <= 1'b0;
      rem_q <= '0;
      sh    <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        neg   <= dividend[PW-1];
        rem_q <= mag[PW-1:PW-2];
        sh    <= {mag[PW-3:0], 2'b00};
        cnt   <= CW'(PW - 2);
        busy  <= 1'b1;
      end else if (busy) begin
        if (trial >= 3'd3) begin
          rem_q <= 2'(trial - 3'd3);
          sh    <= {sh[PW-2:0], 1'b1};
        end else begin
          rem_q <= trial[1:0];
          sh    <= {sh[PW-2:0], 1'b0};
        end
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // After PW-2 steps the shifted-in quotient bits fill sh completely.
  assign quotient  = neg ? -$signed(sh) : $signed(sh);
  assign remainder = rem_q;

endmodule

// File: rtl/tc3_interp_recomp.sv
// Toom-Cook-3 interpolation of r0..r4, recomposition of the 6-limb product and fused addend.
// Single-transaction FSM with a fixed, data-independent latency.
module tc3_interp_recomp import tc3_pkg::*; #(
  parameter int LIMB_W = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  tc3_interp_recomp_if.slave   bus
);

  localparam int PW = pw_of(LIMB_W);
  localparam int RW = 6 * LIMB_W;
  localparam int SW = RW + 1;

  state_t state, state_nx;
  logic   live;
  logic   in_ready, accept, div_start, div_busy, div_done;
  rem_t   rem;

  logic signed [PW-1:0] v0_q, v1_q, vm1_q, v2_q, vinf_q;
  logic signed [PW-1:0] d1, s1, t, r2, r3, r1, u, w, quot;
  logic [RW-1:0]        addend_q;
  logic [SW-1:0]        sum, sum_q;
  logic                 err;

  function automatic logic [SW-1:0] sx(input logic signed [PW-1:0] x);
    return {{(SW-PW){x[PW-1]}}, x};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nx;
      live  <= 1'b1;
    end
  end

  // NOTE: every signal written in always_comb gets a default first, so no latches are inferred.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    div_start = 1'b0;
    case (state)
      IDLE: begin
        in_ready = live;
        if (bus.in_valid && live) state_nx = E1;
      end
      E1:  state_nx = E2;
      E2:  state_nx = E3;
      E3: begin
        div_start = 1'b1;
        state_nx  = DIV;
      end
      DIV: begin
        // An idle divider without done means the start was lost; drop the transaction.
        if (div_done)       state_nx = R1;
        else if (!div_busy) state_nx = IDLE;
      end
      R1:  state_nx = RC;
      RC:  state_nx = OUT;
      OUT: begin
        if (bus.out_ready) begin
          in_ready = 1'b1;
          state_nx = bus.in_valid ? E1 : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept = in_ready & bus.in_valid;

  assign u   = v2_q - v0_q - (r2 <<< 2) - (vinf_q <<< 4);
  assign w   = (u >>> 1) - t;
  assign sum = sx(v0_q) + (sx(r1) << LIMB_W) + (sx(r2) << (2 * LIMB_W))
             + (sx(r3) << (3 * LIMB_W)) + (sx(vinf_q) << (4 * LIMB_W)) + {1'b0, addend_q};

  tc3_div3_serial #(.PW(PW)) u_div3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (w),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (quot),
    .remainder (rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= '0; v1_q <= '0; vm1_q <= '0; v2_q <= '0; vinf_q <= '0;
      addend_q <= '0;
      d1 <= '0; s1 <= '0; t <= '0; r2 <= '0; r3 <= '0; r1 <= '0;
      sum_q <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE, OUT: begin
          if (accept) begin
            v0_q     <= bus.v0;
            v1_q     <= bus.v1;
            vm1_q    <= bus.vm1;
            v2_q     <= bus.v2;
            vinf_q   <= bus.vinf;
            addend_q <= bus.addend;
            err      <= 1'b0;
          end
        end
        E1: begin
          d1 <= v1_q - vm1_q;
          s1 <= v1_q + vm1_q;
        end
        E2: begin
          t   <= d1 >>> 1;
          r2  <= (s1 >>> 1) - v0_q - vinf_q;
          err <= err | d1[0] | s1[0];
        end
        E3:  err <= err | u[0];
        DIV: begin
          if (div_done) begin
            r3  <= quot;
            err <= err | (|rem);
          end
        end
        R1:  r1 <= t - r3;
        RC:  sum_q <= sum;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == OUT);
  assign bus.result    = sum_q[RW-1:0];
  assign bus.out_carry = sum_q[RW];
  assign bus.out_err   = err;

endmodule

// File: tb/tb_tc3_interp_recomp.sv
// Self-checking bench for tc3_interp_recomp at LIMB_W=8: directed cases plus randomized
// limb products checked against a plain a*b+addend model.
module tb_tc3_interp_recomp;
  import tc3_pkg::*;

  localparam int LIMB_W = 8;
  localparam int PW     = pw_of(LIMB_W);
  localparam int RW     = 6 * LIMB_W;
  localparam int LAT    = lat_of(LIMB_W);
  localparam int N_RAND = 1000;
  localparam int BOUND  = 200;

  typedef struct {
    logic signed [PW-1:0] v0, v1, vm1, v2, vinf;
    logic [RW-1:0]        addend;
    logic [RW-1:0]        res;
    logic                 carry;
    logic                 err;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  tc3_interp_recomp_if #(.LIMB_W(LIMB_W)) bus ();

  tc3_interp_recomp #(.LIMB_W(LIMB_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: evaluate both 3-limb operands at 0,1,-1,2,inf and form a*b+addend directly.
  function automatic txn_t make_txn(input int a0, a1, a2, b0, b1, b2, input logic [RW-1:0] addend);
    txn_t   x;
    longint av, bv, p;
    x.v0     = PW'(a0 * b0);
    x.v1     = PW'((a0 + a1 + a2) * (b0 + b1 + b2));
    x.vm1    = PW'((a0 - a1 + a2) * (b0 - b1 + b2));
    x.v2     = PW'((a0 + 2 * a1 + 4 * a2) * (b0 + 2 * b1 + 4 * b2));
    x.vinf   = PW'(a2 * b2);
    x.addend = addend;
    av = longint'(a0) + (longint'(a1) << LIMB_W) + (longint'(a2) << (2 * LIMB_W));
    bv = longint'(b0) + (longint'(b1) << LIMB_W) + (longint'(b2) << (2 * LIMB_W));
    p  = av * bv + longint'(addend);
    x.res   = p[RW-1:0];
    x.carry = p[RW];
    x.err   = 1'b0;
    return x;
  endfunction

  function automatic txn_t rand_txn(input int idx);
    logic [63:0] r;
    int          lim [6];
    r = {$urandom, $urandom};
    for (int k = 0; k < 6; k++) lim[k] = (idx % 50 == 0) ? 255 : int'($urandom_range(0, 255));
    if (idx % 50 == 0) r = '1;
    return make_txn(lim[0], lim[1], lim[2], lim[3], lim[4], lim[5], r[RW-1:0]);
  endfunction

  task automatic drive(input txn_t x);
    bus.v0     = x.v0;
    bus.v1     = x.v1;
    bus.vm1    = x.vm1;
    bus.v2     = x.v2;
    bus.vinf   = x.vinf;
    bus.addend = x.addend;
  endtask

  // Returns #1 after the accept edge.
  task automatic send(input txn_t x, output bit ok);
    logic rdy;
    drive(x);
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < BOUND) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(make_txn(0, 0, 0, 0, 0, 0, '0));
    rst_n = 1'b0;
    #12;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.result !== '0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", bus.result); end
    n_checks++; if (bus.out_carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %b expected 0", bus.out_carry); end
    n_checks++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.out_err); end
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_directed(input string name, input txn_t x);
    bit ok;
    int lat;
    send(x, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL %s_accept: got %b expected 1", name, ok); end
    wait_out(lat);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, LAT); end
    n_checks++; if (bus.result !== x.res) begin n_fail++; $display("FAIL %s_result: got %h expected %h", name, bus.result, x.res); end
    n_checks++; if (bus.out_carry !== x.carry) begin n_fail++; $display("FAIL %s_carry: got %b expected %b", name, bus.out_carry, x.carry); end
    n_checks++; if (bus.out_err !== x.err) begin n_fail++; $display("FAIL %s_err: got %b expected %b", name, bus.out_err, x.err); end
    consume();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_drop_valid: got %b expected 0", name, bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_idle_ready: got %b expected 1", name, bus.in_ready); end
  endtask

  task automatic test_stall_back_to_back(input txn_t c1, input txn_t c2);
    bit ok;
    int lat;
    send(c1, ok);
    wait_out(lat);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL stall_latency: got %0d expected %0d", lat, LAT); end
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, bus.out_valid); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
      n_checks++; if (bus.result !== c1.res) begin n_fail++; $display("FAIL stall_result[%0d]: got %h expected %h", i, bus.result, c1.res); end
      @(posedge clk);
      #1;
    end
    drive(c2);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b expected 1", bus.in_ready); end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    wait_out(lat);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT); end
    n_checks++; if (bus.result !== c2.res) begin n_fail++; $display("FAIL b2b_result: got %h expected %h", bus.result, c2.res); end
    n_checks++; if (bus.out_carry !== c2.carry) begin n_fail++; $display("FAIL b2b_carry: got %b expected %b", bus.out_carry, c2.carry); end
    n_checks++; if (bus.out_err !== c2.err) begin n_fail++; $display("FAIL b2b_err: got %b expected %b", bus.out_err, c2.err); end
    consume();
  endtask

  task automatic test_reset_mid(input txn_t c1);
    bit ok;
    bit seen;
    int lat;
    send(c1, ok);
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid: got %b expected 0", seen); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready: got %b expected 1", bus.in_ready); end
    send(c1, ok);
    wait_out(lat);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL abort_latency: got %0d expected %0d", lat, LAT); end
    n_checks++; if (bus.result !== c1.res) begin n_fail++; $display("FAIL abort_result: got %h expected %h", bus.result, c1.res); end
    n_checks++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL abort_err: got %b expected 0", bus.out_err); end
    consume();
  endtask

  task automatic test_random();
    txn_t cur, nxt;
    bit   pre, ok;
    int   lat, stall;
    cur = rand_txn(0);
    pre = 1'b0;
    for (int i = 0; i < N_RAND; i++) begin
      if (!pre) begin
        send(cur, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rand_accept[%0d]: got %b expected 1", i, ok); end
      end
      wait_out(lat);
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
      n_checks++; if (bus.result !== cur.res) begin n_fail++; $display("FAIL rand_result[%0d]: got %h expected %h", i, bus.result, cur.res); end
      n_checks++; if (bus.out_carry !== cur.carry) begin n_fail++; $display("FAIL rand_carry[%0d]: got %b expected %b", i, bus.out_carry, cur.carry); end
      n_checks++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL rand_err[%0d]: got %b expected 0", i, bus.out_err); end
      stall = $urandom_range(0, 3);
      repeat (stall) begin
        @(posedge clk);
        #1;
      end
      n_checks++; if (bus.result !== cur.res || bus.out_valid !== 1'b1) begin
        n_fail++; $display("FAIL rand_hold[%0d]: got %h/%b expected %h/1", i, bus.result, bus.out_valid, cur.res);
      end
      nxt = rand_txn(i + 1);
      if ($urandom_range(0, 1) == 1 && i < N_RAND - 1) begin
        drive(nxt);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        pre = 1'b1;
      end else begin
        consume();
        pre = 1'b0;
      end
      cur = nxt;
    end
  endtask

  initial begin
    txn_t c1, c2, c3;
    c1 = '{v0: 24'sd4, v1: 24'sd90, vm1: 24'sd10, v2: 24'sd646, vinf: 24'sd18,
           addend: '0, res: 48'h00121B1C0D04, carry: 1'b0, err: 1'b0};
    c2 = '{v0: 24'sd1, v1: 24'sd1, vm1: 24'sd1, v2: 24'sd1, vinf: 24'sd0,
           addend: 48'hFFFFFFFFFFFF, res: '0, carry: 1'b1, err: 1'b0};
    c3 = c1;
    c3.v2  = 24'sd648;
    c3.err = 1'b1;

    test_reset();
    test_directed("case1", c1);
    test_directed("carry", c2);
    test_directed("rem_err", c3);
    test_stall_back_to_back(c1, c2);
    test_reset_mid(c1);
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
